// File: rtl/vmem_wbuf.sv
// Per-core posted-write buffer feeding the shared video-memory write arbiter.
// Define VMEM_WBUF_COALESCE_EN to merge a write to the newest entry's address into that entry.
module vmem_wbuf #(
   parameter int VMEM_ADDRW = 16,
   parameter int DEPTH      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    we_i,
   input  logic [VMEM_ADDRW-1:0]   addr_i,
   input  logic [31:0]             wdata_i,
   output logic                    stall_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [VMEM_ADDRW-1:0]   out_addr_o,
   output logic [31:0]             out_wdata_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   logic [PTRW-1:0]       head_q, head_d;
   logic [PTRW-1:0]       tail_q, tail_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic [VMEM_ADDRW-1:0] mem_addr_q [DEPTH];
   logic [VMEM_ADDRW-1:0] mem_addr_d [DEPTH];
   logic [31:0]           mem_data_q [DEPTH];
   logic [31:0]           mem_data_d [DEPTH];

   logic full, empty, pop, push, coalesce;

   assign full  = (count_q == CNTW'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = out_valid_o & out_ready_i;

`ifdef VMEM_WBUF_COALESCE_EN
   logic [PTRW-1:0] last_ptr;
   assign last_ptr = tail_q - PTRW'(1);
   // Merging into the sole entry while it is being popped would lose the write.
   assign coalesce = we_i & ~empty & (addr_i == mem_addr_q[last_ptr])
                     & ~((count_q == CNTW'(1)) & pop);
`else
   assign coalesce = 1'b0;
`endif

   assign push    = we_i & ~full & ~coalesce;
   assign stall_o = we_i & full & ~coalesce;

   assign out_valid_o = ~empty;
   assign out_addr_o  = empty ? '0 : mem_addr_q[head_q];
   assign out_wdata_o = empty ? '0 : mem_data_q[head_q];
   assign count_o     = count_q;

   always_comb begin
      head_d     = pop  ? head_q + PTRW'(1) : head_q;
      tail_d     = push ? tail_q + PTRW'(1) : tail_q;
      count_d    = count_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
      if (push) begin
         mem_addr_d[tail_q] = addr_i;
         mem_data_d[tail_q] = wdata_i;
      end
`ifdef VMEM_WBUF_COALESCE_EN
      if (coalesce) begin
         mem_data_d[last_ptr] = wdata_i;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr_q[i] <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

endmodule

// File: tb/tb_vmem_wbuf.sv
// Directed bench for vmem_wbuf: per-cycle vector table plus reset and coalesce sequences.
module tb_vmem_wbuf;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        stall, valid;
   logic [15:0] oaddr;
   logic [31:0] odata;
   logic [2:0]  cnt;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef VMEM_WBUF_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   vmem_wbuf #(.VMEM_ADDRW(16), .DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .stall_o(stall), .out_valid_o(valid), .out_ready_i(ready),
      .out_addr_o(oaddr), .out_wdata_o(odata), .count_o(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic        ready;
      logic        e_stall;
      logic        e_valid;
      logic [15:0] e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(logic w, logic [15:0] a, logic [31:0] d, logic r,
                               logic es, logic ev, logic [15:0] ea, logic [31:0] ed,
                               logic [2:0] ec);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = d; v.ready = r;
      v.e_stall = es; v.e_valid = ev; v.e_addr = ea; v.e_data = ed; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic w, logic [15:0] a, logic [31:0] d, logic r);
      we = w; addr = a; wdata = d; ready = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Expected values are the outputs seen in the cycle the inputs are applied (before the edge).
      vecs[0]  = mk(1, 16'h0010, 32'h0000F800, 0, 0, 0, 16'h0000, 32'h0, 3'd0);
      vecs[1]  = mk(0, 16'h0000, 32'h0,        0, 0, 1, 16'h0010, 32'h0000F800, 3'd1);
      vecs[2]  = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0010, 32'h0000F800, 3'd1);
      vecs[3]  = mk(0, 16'h0000, 32'h0,        0, 0, 0, 16'h0000, 32'h0, 3'd0);
      vecs[4]  = mk(1, 16'h0001, 32'h101,      0, 0, 0, 16'h0000, 32'h0,   3'd0);
      vecs[5]  = mk(1, 16'h0002, 32'h102,      0, 0, 1, 16'h0001, 32'h101, 3'd1);
      vecs[6]  = mk(1, 16'h0003, 32'h103,      0, 0, 1, 16'h0001, 32'h101, 3'd2);
      vecs[7]  = mk(1, 16'h0004, 32'h104,      0, 0, 1, 16'h0001, 32'h101, 3'd3);
      vecs[8]  = mk(1, 16'h0005, 32'h105,      0, 1, 1, 16'h0001, 32'h101, 3'd4);
      vecs[9]  = mk(1, 16'h0005, 32'h105,      1, 1, 1, 16'h0001, 32'h101, 3'd4);
      vecs[10] = mk(1, 16'h0005, 32'h105,      0, 0, 1, 16'h0002, 32'h102, 3'd3);
      vecs[11] = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0002, 32'h102, 3'd4);
      vecs[12] = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0003, 32'h103, 3'd3);
      vecs[13] = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0004, 32'h104, 3'd2);
      vecs[14] = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0005, 32'h105, 3'd1);
      vecs[15] = mk(0, 16'h0000, 32'h0,        0, 0, 0, 16'h0000, 32'h0,   3'd0);
      vecs[16] = mk(1, 16'h0020, 32'h200,      1, 0, 0, 16'h0000, 32'h0,   3'd0);
      vecs[17] = mk(1, 16'h0021, 32'h201,      1, 0, 1, 16'h0020, 32'h200, 3'd1);
      vecs[18] = mk(1, 16'h0022, 32'h202,      1, 0, 1, 16'h0021, 32'h201, 3'd1);
      vecs[19] = mk(0, 16'h0000, 32'h0,        1, 0, 1, 16'h0022, 32'h202, 3'd1);
      vecs[20] = mk(0, 16'h0000, 32'h0,        0, 0, 0, 16'h0000, 32'h0,   3'd0);

      rst = 1'b1;
      drive(1, 16'h0033, 32'h33, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_count", {29'b0, cnt},   32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_addr",  {16'b0, oaddr}, 32'd0);
      drive(0, 16'h0, 32'h0, 0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d_addr",  i), {16'b0, oaddr}, {16'b0, vecs[i].e_addr});
         chk($sformatf("v%0d_data",  i), odata,          vecs[i].e_data);
         chk($sformatf("v%0d_count", i), {29'b0, cnt},   {29'b0, vecs[i].e_cnt});
         next_cycle();
      end

      // Asynchronous reset with three entries pending and a write in flight.
      for (int i = 0; i < 3; i++) begin
         drive(1, 16'h0061 + 16'(i), 32'h610 + 32'(i), 0);
         next_cycle();
      end
      chk("ar_pre_count", {29'b0, cnt}, 32'd3);
      drive(1, 16'h0064, 32'h640, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", {31'b0, valid}, 32'd0);
      chk("ar_count", {29'b0, cnt},   32'd0);
      chk("ar_addr",  {16'b0, oaddr}, 32'd0);
      chk("ar_data",  odata,          32'd0);
      chk("ar_stall", {31'b0, stall}, 32'd0);
      drive(0, 16'h0, 32'h0, 0);
      #2 rst = 1'b0;
      next_cycle();
      drive(1, 16'h0070, 32'h700, 0);
      next_cycle();
      drive(0, 16'h0, 32'h0, 1);
      @(negedge clk);
      chk("ar_new_count", {29'b0, cnt},   32'd1);
      chk("ar_new_addr",  {16'b0, oaddr}, 32'h70);
      chk("ar_new_data",  odata,          32'h700);
      next_cycle();
      drive(0, 16'h0, 32'h0, 0);
      @(negedge clk);
      chk("ar_after_pop_valid", {31'b0, valid}, 32'd0);
      next_cycle();

      // Rewrite of the newest entry's address while full.
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'h0010 * 16'(i + 1), 32'h401 + 32'(i), 0);
         next_cycle();
      end
      drive(1, 16'h0040, 32'h1234, 0);
      @(negedge clk);
      chk("co_stall", {31'b0, stall}, COAL ? 32'd0 : 32'd1);
      chk("co_count", {29'b0, cnt},   32'd4);
      next_cycle();
      drive(0, 16'h0, 32'h0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("co_drain%0d_addr", i), {16'b0, oaddr}, 32'h10 * 32'(i + 1));
         chk($sformatf("co_drain%0d_data", i), odata,
             (i == 3 && COAL) ? 32'h1234 : 32'h401 + 32'(i));
         next_cycle();
      end
      drive(0, 16'h0, 32'h0, 0);
      @(negedge clk);
      chk("co_empty_count", {29'b0, cnt}, 32'd0);
      next_cycle();

      // Same-address write while the single entry is being popped: must be a new entry.
      drive(1, 16'h0050, 32'hAAAA, 0);
      next_cycle();
      drive(1, 16'h0050, 32'hBBBB, 1);
      @(negedge clk);
      chk("c1_stall", {31'b0, stall}, 32'd0);
      chk("c1_head",  odata,          32'hAAAA);
      next_cycle();
      drive(0, 16'h0, 32'h0, 0);
      @(negedge clk);
      chk("c1_count", {29'b0, cnt},   32'd1);
      chk("c1_addr",  {16'b0, oaddr}, 32'h50);
      chk("c1_data",  odata,          32'hBBBB);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
